// File: rtl/sample_readout_ctrl_pkg.sv
// rtl/sample_readout_ctrl_pkg.sv - shared state encoding and default sizing for the readout sequencer
package sample_readout_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_PUSH   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam int NCH_DEF    = 8;
  localparam int CH_W_DEF   = 3;
  localparam int DW_DEF     = 16;
  localparam int SETTLE_DEF = 4;

endpackage

// File: rtl/sample_readout_ctrl_if.sv
// rtl/sample_readout_ctrl_if.sv - tagged sample word handshake toward the SDRAM write FIFO
interface sample_readout_ctrl_if #(
  parameter int CH_W = 3,
  parameter int DW   = 16
);
  logic [CH_W-1:0] ch_sel;
  logic [DW-1:0]   wr_data;
  logic            wr_valid;
  logic            wr_ready;

  modport master (output ch_sel, output wr_data, output wr_valid, input wr_ready);
  modport slave  (input ch_sel, input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/sample_readout_ctrl_rise_detect.sv
// rtl/sample_readout_ctrl_rise_detect.sv - single-bit rising edge detector, history cleared by reset
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;
endmodule

// File: rtl/sample_readout_ctrl.sv
// rtl/sample_readout_ctrl.sv - per-strobe multi-channel readout frame sequencer
// Steps the mux, waits the settle time, captures each channel and pushes it to the FIFO.
module sample_readout_ctrl
  import sample_readout_ctrl_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int CH_W   = CH_W_DEF,
  parameter int DW     = DW_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                  clk,
  input  logic                  clk_rst,
  input  logic                  enable,
  input  logic [31:0]           frame_limit,
  input  logic                  tick,
  input  logic [DW-1:0]         adc_data,
  output logic [31:0]           frame_cnt,
  output logic                  busy,
  output logic                  overrun,
  output logic                  done,
  sample_readout_ctrl_if.master wr_if
);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);
  localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(NCH - 1);

  state_e            r_state, w_state_nxt;
  logic [SET_W-1:0]  r_settle_cnt, w_settle_nxt;
  logic [CH_W-1:0]   r_ch_sel, w_ch_nxt;
  logic [DW-1:0]     r_wr_data, w_data_nxt;
  logic              r_wr_valid, w_valid_nxt;
  logic [31:0]       r_frame_cnt, w_fcnt_nxt, w_fcnt_inc;
  logic              r_overrun, w_ovr_nxt;
  logic              r_done, w_done_nxt;
  logic              w_tick_e, w_en_e, w_hs;

  rise_detect u_tick_rise (.clk(clk), .rst(clk_rst), .i_d(tick),   .o_rise(w_tick_e));
  rise_detect u_en_rise   (.clk(clk), .rst(clk_rst), .i_d(enable), .o_rise(w_en_e));

  assign w_hs       = r_wr_valid & wr_if.wr_ready;
  assign w_fcnt_inc = (r_frame_cnt == 32'hFFFF_FFFF) ? r_frame_cnt : r_frame_cnt + 32'd1;

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_ch_sel     <= '0;
      r_wr_data    <= '0;
      r_wr_valid   <= 1'b0;
      r_frame_cnt  <= '0;
      r_overrun    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_ch_sel     <= w_ch_nxt;
      r_wr_data    <= w_data_nxt;
      r_wr_valid   <= w_valid_nxt;
      r_frame_cnt  <= w_fcnt_nxt;
      r_overrun    <= w_ovr_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    w_ch_nxt     = r_ch_sel;
    w_data_nxt   = r_wr_data;
    w_valid_nxt  = r_wr_valid;
    w_fcnt_nxt   = r_frame_cnt;
    w_ovr_nxt    = r_overrun;
    w_done_nxt   = r_done;
    case (r_state)
      S_IDLE: begin
        if (w_en_e) begin
          w_fcnt_nxt  = '0;
          w_ovr_nxt   = 1'b0;
          w_done_nxt  = 1'b0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          w_ch_nxt    = '0;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_tick_e) begin
          w_ch_nxt     = '0;
          w_settle_nxt = SETTLE_LOAD;
          w_state_nxt  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_tick_e) w_ovr_nxt = 1'b1;
        if (!enable) begin
          w_ch_nxt    = '0;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_settle_cnt == '0) begin
          w_data_nxt  = adc_data;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_PUSH;
        end else begin
          w_settle_nxt = r_settle_cnt - 1'b1;
        end
      end
      S_PUSH: begin
        if (w_tick_e) w_ovr_nxt = 1'b1;
        // the offered word is never withdrawn: abort only takes effect on its handshake
        if (w_hs) begin
          w_valid_nxt = 1'b0;
          if (!enable) begin
            w_ch_nxt    = '0;
            w_state_nxt = S_IDLE;
          end else if (r_ch_sel != CH_LAST) begin
            w_ch_nxt     = r_ch_sel + 1'b1;
            w_settle_nxt = SETTLE_LOAD;
            w_state_nxt  = S_SETTLE;
          end else begin
            w_fcnt_nxt = w_fcnt_inc;
            w_ch_nxt   = '0;
            if (frame_limit != 32'd0 && w_fcnt_inc == frame_limit) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end
        end
      end
      S_DONE: begin
        if (!enable) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign wr_if.ch_sel   = r_ch_sel;
  assign wr_if.wr_data  = r_wr_data;
  assign wr_if.wr_valid = r_wr_valid;
  assign frame_cnt      = r_frame_cnt;
  assign busy           = (r_state == S_SETTLE) || (r_state == S_PUSH);
  assign overrun        = r_overrun;
  assign done           = r_done;
endmodule

// File: tb/tb_sample_readout_ctrl.sv
// tb/tb_sample_readout_ctrl.sv - scoreboard bench for the readout frame sequencer
module tb_sample_readout_ctrl;
  import sample_readout_ctrl_pkg::*;

  localparam int NCH = 8, CH_W = 3, DW = 16, SETTLE = 4;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [DW-1:0]   data;
  } word_t;

  logic        clk = 1'b0;
  logic        clk_rst = 1'b1;
  logic        enable = 1'b0;
  logic        tick = 1'b0;
  logic [31:0] frame_limit = 32'd0;
  logic [DW-1:0] adc_data;
  logic [31:0] frame_cnt;
  logic        busy, overrun, done;

  logic [3:0]  seed = 4'd0;
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  logic        hold_low = 1'b1;
  int          stall_left = 0;
  logic        rst_q = 1'b0;
  word_t       sb[$];
  int          hs_q[$];
  logic        prev_stall = 1'b0;
  logic [DW-1:0]   prev_data = '0;
  logic [CH_W-1:0] prev_ch = '0;

  sample_readout_ctrl_if #(.CH_W(CH_W), .DW(DW)) wr_if();

  sample_readout_ctrl #(.NCH(NCH), .CH_W(CH_W), .DW(DW), .SETTLE(SETTLE)) dut (
    .clk(clk), .clk_rst(clk_rst), .enable(enable), .frame_limit(frame_limit),
    .tick(tick), .adc_data(adc_data), .frame_cnt(frame_cnt), .busy(busy),
    .overrun(overrun), .done(done), .wr_if(wr_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= clk_rst;
  end

  // each channel returns a word that encodes the frame seed and its own index
  assign adc_data = {4'hA, seed, 5'b0, wr_if.ch_sel};

  function automatic logic [DW-1:0] exp_word(input logic [3:0] s, input int ch);
    logic [CH_W-1:0] c;
    c = CH_W'(ch);
    return {4'hA, s, 5'b0, c};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic expect_frame();
    for (int i = 0; i < NCH; i++) sb.push_back({CH_W'(i), exp_word(seed, i)});
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1 tick = 1'b1;
    repeat (3) @(posedge clk);
    #1 tick = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int c);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_if.wr_valid) break;
    end
    c = cyc;
    if (i == 200) chk(nm, 64'd0, 64'd1);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    wr_if.wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_low) wr_if.wr_ready = 1'b0;
      else if (stall_left > 0 && wr_if.wr_valid && wr_if.ch_sel == 3'd3) begin
        wr_if.wr_ready = 1'b0;
        stall_left--;
      end else wr_if.wr_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    word_t e;
    if (prev_stall && !rst_q) begin
      chk("hold_valid", 64'(wr_if.wr_valid), 64'd1);
      chk("hold_data", 64'(wr_if.wr_data), 64'(prev_data));
      chk("hold_ch", 64'(wr_if.ch_sel), 64'(prev_ch));
    end
    if (wr_if.wr_valid && wr_if.wr_ready) begin
      hs_q.push_back(cyc);
      if (sb.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_word: got ch=%0d data=%h want none", wr_if.ch_sel, wr_if.wr_data);
      end else begin
        e = sb.pop_front();
        chk("word_ch", 64'(wr_if.ch_sel), 64'(e.ch));
        chk("word_data", 64'(wr_if.wr_data), 64'(e.data));
      end
    end
    prev_stall = wr_if.wr_valid && !wr_if.wr_ready;
    prev_data  = wr_if.wr_data;
    prev_ch    = wr_if.ch_sel;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int k, c;
    repeat (3) @(posedge clk);
    #1 clk_rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(wr_if.wr_valid), 64'd0);
    chk("rst_ch", 64'(wr_if.ch_sel), 64'd0);
    chk("rst_data", 64'(wr_if.wr_data), 64'd0);
    chk("rst_fcnt", 64'(frame_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_state", 64'(dut.r_state), 64'(S_IDLE));

    // basic frame: latency and word spacing
    hold_low = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    repeat (5) @(posedge clk);
    expect_frame();
    hs_q.delete();
    @(posedge clk); #1 tick = 1'b1;
    k = cyc;
    wait_valid("t2_valid_timeout", c);
    chk("t2_latency", 64'(c - k), 64'(1 + SETTLE));
    @(posedge clk); #1 tick = 1'b0;
    drain("t2_drain");
    chk("t2_words", 64'(hs_q.size()), 64'(NCH));
    for (int i = 1; i < hs_q.size(); i++) chk("t2_spacing", 64'(hs_q[i] - hs_q[i-1]), 64'(SETTLE + 1));
    chk("t2_fcnt", 64'(frame_cnt), 64'd1);

    // backpressure on channel 3
    seed = 4'd1;
    stall_left = 3;
    hs_q.delete();
    expect_frame();
    pulse_tick();
    drain("t3_drain");
    chk("t3_words", 64'(hs_q.size()), 64'(NCH));
    chk("t3_stalled", 64'(stall_left), 64'd0);
    chk("t3_fcnt", 64'(frame_cnt), 64'd2);

    // frame limit of 2
    @(posedge clk); #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 frame_limit = 32'd2; enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_arm_fcnt", 64'(frame_cnt), 64'd0);
    seed = 4'd2;
    expect_frame();
    expect_frame();
    pulse_tick();
    repeat (96) @(posedge clk);
    pulse_tick();
    repeat (60) @(negedge clk);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_fcnt", 64'(frame_cnt), 64'd2);
    chk("t4_sb", 64'(sb.size()), 64'd0);
    repeat (36) @(posedge clk);
    pulse_tick();
    repeat (60) @(negedge clk);
    chk("t4_busy3", 64'(busy), 64'd0);
    chk("t4_ovr", 64'(overrun), 64'd0);
    chk("t4_done3", 64'(done), 64'd1);
    chk("t4_fcnt3", 64'(frame_cnt), 64'd2);
    @(posedge clk); #1 enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_done_hold", 64'(done), 64'd1);
    chk("t4_idle", 64'(dut.r_state), 64'(S_IDLE));

    // overrun from a second strobe mid-frame
    @(posedge clk); #1 frame_limit = 32'd0; enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_done_clr", 64'(done), 64'd0);
    seed = 4'd3;
    hs_q.delete();
    expect_frame();
    @(posedge clk); #1 tick = 1'b1;
    repeat (3) @(posedge clk);
    #1 tick = 1'b0;
    repeat (7) @(posedge clk);
    #1 tick = 1'b1;
    repeat (2) @(posedge clk);
    #1 tick = 1'b0;
    @(negedge clk);
    chk("t5_ovr", 64'(overrun), 64'd1);
    drain("t5_drain1");
    chk("t5_fcnt1", 64'(frame_cnt), 64'd1);
    seed = 4'd4;
    expect_frame();
    pulse_tick();
    drain("t5_drain2");
    chk("t5_words", 64'(hs_q.size()), 64'(2 * NCH));
    chk("t5_fcnt2", 64'(frame_cnt), 64'd2);
    chk("t5_ovr_sticky", 64'(overrun), 64'd1);

    // abort while a word is pending
    @(posedge clk); #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1; hold_low = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_ovr_clr", 64'(overrun), 64'd0);
    seed = 4'd5;
    sb.push_back({CH_W'(0), exp_word(seed, 0)});
    pulse_tick();
    wait_valid("t6_valid_timeout", c);
    @(posedge clk); #1 enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_held_valid", 64'(wr_if.wr_valid), 64'd1);
    chk("t6_held_ch", 64'(wr_if.ch_sel), 64'd0);
    chk("t6_held_busy", 64'(busy), 64'd1);
    hold_low = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_sb", 64'(sb.size()), 64'd0);
    chk("t6_valid_off", 64'(wr_if.wr_valid), 64'd0);
    chk("t6_busy_off", 64'(busy), 64'd0);
    chk("t6_idle", 64'(dut.r_state), 64'(S_IDLE));
    chk("t6_fcnt", 64'(frame_cnt), 64'd0);

    // reset while a word is pending: the word is dropped, not delivered
    hold_low = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    repeat (3) @(posedge clk);
    pulse_tick();
    wait_valid("t6r_valid_timeout", c);
    @(posedge clk); #1 clk_rst = 1'b1;
    @(posedge clk); #1;
    chk("t6r_valid", 64'(wr_if.wr_valid), 64'd0);
    clk_rst = 1'b0;
    chk("t6r_busy", 64'(busy), 64'd0);
    chk("t6r_fcnt", 64'(frame_cnt), 64'd0);
    hold_low = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6r_sb", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
